// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//
// Sits directly downstream of uart_rx and gathers the received byte stream
// into one FULL_DATA_SIZE-bit message word, using the same layout that
// uart_tx consumes:
//
//   full_data[FDS-1 -: BYTE_SIZE]            opt byte
//   full_data[FDS-BYTE_SIZE-1 -: BYTE_SIZE]  len byte
//   full_data[BYTE_SIZE*i +: BYTE_SIZE]      payload byte i (receive order)
//
// Unused payload slots read as zero. The wire frame is opt, len, then len
// payload bytes. A finished word is offered on a valid/ready handshake and
// held stable until it is accepted.
//
// Ports
//   CLK        in   single clock, rising edge
//   RST        in   asynchronous active-low reset
//   in_byte    in   byte from uart_rx
//   in_valid   in   1-cycle strobe qualifying in_byte
//   full_data  out  assembled message word
//   out_valid  out  full_data valid, held until out_ready
//   out_ready  in   consumer accepts full_data (ignored unless holding)
//   busy       out  a frame is being collected or is awaiting acceptance
//   err_len    out  1-cycle pulse: len byte exceeds the payload capacity
//   err_tmo    out  1-cycle pulse: inter-byte gap too long inside a frame
//   err_ovr    out  1-cycle pulse: byte arrived while a word was waiting
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int unsigned FULL_DATA_SIZE = 40,
    parameter int unsigned BYTE_SIZE      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [BYTE_SIZE-1:0]      in_byte,
    input  logic                      in_valid,
    output logic [FULL_DATA_SIZE-1:0] full_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err_len,
    output logic                      err_tmo,
    output logic                      err_ovr
);

    localparam int unsigned MAX_PAYLOAD = FULL_DATA_SIZE / BYTE_SIZE - 2;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES);

    localparam logic [BYTE_SIZE-1:0] MAX_LEN  = BYTE_SIZE'(MAX_PAYLOAD);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Registered state
    logic [1:0]                state_q, state_d;
    logic [FULL_DATA_SIZE-1:0] data_q,  data_d;
    logic [BYTE_SIZE-1:0]      len_q,   len_d;
    logic [BYTE_SIZE-1:0]      cnt_q,   cnt_d;
    logic [TW-1:0]             tmo_q,   tmo_d;
    logic                      err_len_q, err_len_d;
    logic                      err_tmo_q, err_tmo_d;
    logic                      err_ovr_q, err_ovr_d;

    // Shared action for IDLE and for the HOLD accept-and-restart case:
    // the arriving byte becomes the opt of a fresh frame with an empty payload.
    function automatic logic [FULL_DATA_SIZE-1:0] start_frame(
        input logic [FULL_DATA_SIZE-1:0] cur,
        input logic [BYTE_SIZE-1:0]      opt
    );
        logic [FULL_DATA_SIZE-1:0] w;
        w = cur;
        w[FULL_DATA_SIZE-1 -: BYTE_SIZE] = opt;
        for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
            w[i*BYTE_SIZE +: BYTE_SIZE] = '0;
        end
        return w;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (in_valid) begin
                    data_d  = start_frame(data_q, in_byte);
                    cnt_d   = '0;
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (in_valid) begin
                    tmo_d = '0;
                    if (in_byte > MAX_LEN) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        data_d[FULL_DATA_SIZE-BYTE_SIZE-1 -: BYTE_SIZE] = in_byte;
                        len_d   = in_byte;
                        cnt_d   = '0;
                        state_d = (in_byte == '0) ? ST_HOLD : ST_PAYLOAD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_PAYLOAD: begin
                if (in_valid) begin
                    tmo_d = '0;
                    // Slot decode rather than a variable part-select keeps the
                    // write provably inside the payload field for any cnt value.
                    for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                        if (cnt_q == BYTE_SIZE'(i)) begin
                            data_d[i*BYTE_SIZE +: BYTE_SIZE] = in_byte;
                        end
                    end
                    cnt_d = cnt_q + BYTE_SIZE'(1);
                    if (cnt_q + BYTE_SIZE'(1) == len_q) begin
                        state_d = ST_HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_HOLD: begin
                tmo_d = '0;
                if (out_ready) begin
                    // Handshake completes; a byte in the same cycle starts
                    // the next frame instead of being reported as an overrun.
                    if (in_valid) begin
                        data_d  = start_frame(data_q, in_byte);
                        cnt_d   = '0;
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (in_valid) begin
                    err_ovr_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // -----------------------------------------------------------------------
    assign full_data = data_q;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign err_len   = err_len_q;
    assign err_tmo   = err_tmo_q;
    assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Directed frames against a queue-based frame model: bytes of the current
// frame are pushed into a queue, and the word is built from the queue once
// opt + len + len payload bytes have arrived. A compare process checks every
// output on every falling edge while out of reset. Literal expectations in
// the stimulus pin the model to hand-computed words and pulse timing.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int FDS  = 40;
    localparam int BS   = 8;
    localparam int TMO  = 32;
    localparam int MAXP = FDS / BS - 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic [BS-1:0]  in_byte = '0;
    logic           in_valid = 1'b0;
    logic [FDS-1:0] full_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           err_len;
    logic           err_tmo;
    logic           err_ovr;

    int tests = 0;
    int fails = 0;

    uart_rx_deframer #(
        .FULL_DATA_SIZE (FDS),
        .BYTE_SIZE      (BS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .full_data (full_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err_len   (err_len),
        .err_tmo   (err_tmo),
        .err_ovr   (err_ovr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [7:0]     frame[$];
    bit             holding = 1'b0;
    logic [FDS-1:0] held = '0;
    int             gap = 0;
    bit             e_len = 1'b0, e_tmo = 1'b0, e_ovr = 1'b0;

    function automatic logic [FDS-1:0] assemble();
        logic [FDS-1:0] w;
        w = '0;
        w[FDS-1 -: 8]    = frame[0];
        w[FDS-9 -: 8]    = frame[1];
        for (int i = 0; i < int'(frame[1]); i++) w[i*8 +: 8] = frame[2+i];
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                frame.delete();
                holding = 1'b0;
                held    = '0;
                gap     = 0;
                e_len   = 1'b0; e_tmo = 1'b0; e_ovr = 1'b0;
            end else begin
                e_len = 1'b0; e_tmo = 1'b0; e_ovr = 1'b0;
                if (holding) begin
                    if (out_ready) begin
                        holding = 1'b0;
                        if (in_valid) begin
                            frame.push_back(in_byte);
                            gap = 0;
                        end
                    end else if (in_valid) begin
                        e_ovr = 1'b1;
                    end
                end else if (frame.size() == 0) begin
                    if (in_valid) begin
                        frame.push_back(in_byte);
                        gap = 0;
                    end
                end else if (in_valid) begin
                    frame.push_back(in_byte);
                    gap = 0;
                    if (frame.size() == 2 && int'(frame[1]) > MAXP) begin
                        e_len = 1'b1;
                        frame.delete();
                    end else if (frame.size() == 2 + int'(frame[1])) begin
                        held    = assemble();
                        holding = 1'b1;
                        frame.delete();
                    end
                end else begin
                    gap++;
                    if (gap == TMO) begin
                        e_tmo = 1'b1;
                        frame.delete();
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------- compare
    always @(negedge CLK) begin
        if (RST) begin
            chk("out_valid", 64'(out_valid), 64'(holding));
            chk("busy", 64'(busy), 64'(holding || frame.size() != 0));
            chk("err_len", 64'(err_len), 64'(e_len));
            chk("err_tmo", 64'(err_tmo), 64'(e_tmo));
            chk("err_ovr", 64'(err_ovr), 64'(e_ovr));
            if (holding) chk("full_data", 64'(full_data), 64'(held));
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic accept();
        @(negedge CLK);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    initial begin
        int tmo_at;
        int tmo_cnt;

        // Reset state
        #3;
        chk("rst_full_data", 64'(full_data), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_errs", 64'({err_len, err_tmo, err_ovr}), 64'h0);
        idle(2);
        RST = 1'b1;
        idle(2);

        // 1: two-byte payload with gaps, held while not ready
        send(8'h00); idle(4);
        send(8'h02); idle(4);
        send(8'haa); idle(4);
        chk("t1_not_yet", 64'(out_valid), 64'h0);
        send(8'hbb);
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_word", 64'(full_data), 64'h00_02_00_bb_aa);
        idle(6);
        chk("t1_held_valid", 64'(out_valid), 64'h1);
        chk("t1_held_word", 64'(full_data), 64'h00_02_00_bb_aa);
        accept();
        chk("t1_released", 64'(out_valid), 64'h0);

        // 2: empty payload
        send(8'h01);
        send(8'h00);
        chk("t2_valid", 64'(out_valid), 64'h1);
        chk("t2_word", 64'(full_data), 64'h01_00_00_00_00);
        accept();

        // 3: length error, then a full-capacity frame
        send(8'h00);
        send(8'h04);
        chk("t3_err_len", 64'(err_len), 64'h1);
        chk("t3_idle", 64'(busy), 64'h0);
        idle(1);
        chk("t3_err_len_gone", 64'(err_len), 64'h0);
        send(8'h05); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("t3_word", 64'(full_data), 64'h05_03_33_22_11);
        accept();

        // 4: timeout mid-payload, then a clean frame
        send(8'h07); send(8'h03); send(8'h44);
        tmo_at = 0;
        tmo_cnt = 0;
        for (int k = 1; k <= TMO + 8; k++) begin
            @(negedge CLK);
            if (err_tmo) begin
                tmo_cnt++;
                if (tmo_at == 0) tmo_at = k;
            end
        end
        chk("t4_tmo_cycle", 64'(tmo_at), 64'(TMO));
        chk("t4_tmo_once", 64'(tmo_cnt), 64'h1);
        chk("t4_idle", 64'({busy, out_valid}), 64'h0);
        send(8'h09); send(8'h01); send(8'h5a);
        chk("t4_word", 64'(full_data), 64'h09_01_00_00_5a);
        accept();

        // 5: overrun in HOLD, then simultaneous accept and new opt
        send(8'h02); send(8'h01); send(8'h77);
        send(8'hee);
        chk("t5_ovr", 64'(err_ovr), 64'h1);
        chk("t5_still_valid", 64'(out_valid), 64'h1);
        chk("t5_word_kept", 64'(full_data), 64'h02_01_00_00_77);
        @(negedge CLK);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_byte   = 8'h03;
        @(negedge CLK);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t5_handoff_valid", 64'(out_valid), 64'h0);
        chk("t5_handoff_busy", 64'(busy), 64'h1);
        chk("t5_no_ovr", 64'(err_ovr), 64'h0);
        send(8'h00);
        chk("t5_word2", 64'(full_data), 64'h03_00_00_00_00);
        accept();

        // 6: asynchronous reset mid-payload, then a clean frame
        send(8'h08); send(8'h03); send(8'haa);
        #2;
        RST = 1'b0;
        #1;
        chk("t6_rst_data", 64'(full_data), 64'h0);
        chk("t6_rst_flags", 64'({out_valid, busy, err_len, err_tmo, err_ovr}), 64'h0);
        idle(2);
        RST = 1'b1;
        send(8'h0a); send(8'h01); send(8'hbc);
        chk("t6_word", 64'(full_data), 64'h0a_01_00_00_bc);
        accept();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
